fp32_mult_ctrl: RTL and testbench

//  Sequencer wrapping the 24-bit sequential mantissa multiplier into an IEEE-754

---
 rtl/fp32_mult_ctrl.sv | 140 ++++++++++++++
 tb/tb_fp32_mult_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mult_ctrl.sv
// fp32_mult_ctrl: IEEE-754 single-precision multiply sequencer around a 24-bit sequential mantissa multiplier (ROUND_NEAREST_EN selects round-nearest-even, otherwise truncate)
module fp32_mult_ctrl #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] CANON_NAN      = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        inv,
  output logic        tmo,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  output logic        mul_start,
  input  logic [47:0] mul_result,
  input  logic        mul_done
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_ISSUE, S_SKIP, S_WAIT, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;
  state_t             state;
  logic [31:0]        ra, rb;
  logic               sign;
  logic signed [9:0]  e;
  logic [22:0]        frac;
  logic [47:0]        prod;
  logic [CW-1:0]      cnt;
  logic               za, zb, ia, ib, na, nb, sgn, inc;
  logic [23:0]        fsum;
  logic signed [9:0]  er;
  assign busy = state != S_IDLE;
  assign sgn  = ra[31] ^ rb[31];
  assign za   = ra[30:23] == 8'h00;
  assign zb   = rb[30:23] == 8'h00;
  assign ia   = ra[30:23] == 8'hFF && ra[22:0] == 23'h0;
  assign ib   = rb[30:23] == 8'hFF && rb[22:0] == 23'h0;
  assign na   = ra[30:23] == 8'hFF && ra[22:0] != 23'h0;
  assign nb   = rb[30:23] == 8'hFF && rb[22:0] != 23'h0;
`ifdef ROUND_NEAREST_EN
  logic g, st;
  assign inc = g & (st | frac[0]);
`else
  assign inc = 1'b0;
`endif
  // A rounding carry out of the fraction leaves fsum[22:0] at zero and bumps the exponent
  assign fsum = {1'b0, frac} + {23'h0, inc};
  assign er   = e + (fsum[23] ? 10'sd1 : 10'sd0);
  // Sequencer: unpack, launch multiplier, normalize, round, pack; outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      result    <= 32'h0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inv       <= 1'b0;
      tmo       <= 1'b0;
      mul_a     <= 24'h0;
      mul_b     <= 24'h0;
      mul_start <= 1'b0;
    end else begin
      done      <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ra     <= a;
          rb     <= b;
          result <= 32'h0;
          {ovf, unf, inv, tmo} <= 4'b0;
          state  <= S_UNPACK;
        end
        S_UNPACK: begin
          sign <= sgn;
          e    <= 10'({2'b0, ra[30:23]} + {2'b0, rb[30:23]} - 10'd127);
          if (na || nb || (ia && zb) || (za && ib)) begin
            result <= CANON_NAN;
            inv    <= 1'b1;
            state  <= S_PACK;
          end else if (ia || ib) begin
            result <= {sgn, 8'hFF, 23'h0};
            state  <= S_PACK;
          end else if (za || zb) begin
            result <= {sgn, 31'h0};
            state  <= S_PACK;
          end else begin
            mul_a     <= {1'b1, ra[22:0]};
            mul_b     <= {1'b1, rb[22:0]};
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_SKIP;
        S_SKIP: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            prod  <= mul_result;
            state <= S_NORM;
          end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
            tmo    <= 1'b1;
            result <= CANON_NAN;
            state  <= S_PACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NORM: begin
          frac <= prod[47] ? prod[46:24] : prod[45:23];
          e    <= prod[47] ? e + 10'sd1 : e;
`ifdef ROUND_NEAREST_EN
          g    <= prod[47] ? prod[23] : prod[22];
          st   <= prod[47] ? |prod[22:0] : |prod[21:0];
`endif
          state <= S_ROUND;
        end
        S_ROUND: begin
          result <= er >= 10'sd255 ? {sign, 8'hFF, 23'h0} :
                    er <= 10'sd0   ? {sign, 31'h0} : {sign, er[7:0], fsum[22:0]};
          ovf    <= er >= 10'sd255;
          unf    <= er <= 10'sd0;
          state  <= S_PACK;
        end
        S_PACK: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_mult_ctrl.sv
// tb_fp32_mult_ctrl: randomized and directed checks of fp32_mult_ctrl against a real-arithmetic reference model
module tb_fp32_mult_ctrl;
  localparam int TMO = 64;
  logic        clk = 1'b0, rst, start;
  logic [31:0] a, b, result;
  logic        busy, done, ovf, unf, inv, tmo, mul_start, mul_done;
  logic [23:0] mul_a, mul_b;
  logic [47:0] mul_result;
  int checks = 0, errors = 0;

  fp32_mult_ctrl #(.TIMEOUT_CYCLES(TMO), .CANON_NAN(32'h7FC00000)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .ovf(ovf), .unf(unf), .inv(inv), .tmo(tmo), .mul_a(mul_a),
    .mul_b(mul_b), .mul_start(mul_start), .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // Multiplier core stand-in: product ready lat cycles after launch, done held high until next launch
  int lat = 1, m_cnt = 0, starts = 0;
  bit hang = 0;
  initial begin mul_done = 1'b0; mul_result = 48'h0; end
  always @(posedge clk) begin
    if (mul_start) begin
      starts     <= starts + 1;
      mul_done   <= 1'b0;
      mul_result <= {24'h0, mul_a} * {24'h0, mul_b};
      m_cnt      <= hang ? 0 : lat;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mul_done <= 1'b1;
    end
  end

  // Reference: exact real product, normalized by halving, then truncated or rounded to nearest-even
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    bit zx, zy, ix, iy, nx, ny;
    real m, rem;
    int e, f;
    s  = x[31] ^ y[31];
    zx = x[30:23] == 0;
    zy = y[30:23] == 0;
    ix = x[30:23] == 255 && x[22:0] == 0;
    iy = y[30:23] == 255 && y[22:0] == 0;
    nx = x[30:23] == 255 && x[22:0] != 0;
    ny = y[30:23] == 255 && y[22:0] != 0;
    if (nx || ny || (ix && zy) || (zx && iy)) return {32'h7FC00000, 4'b0010};
    if (ix || iy) return {s, 8'hFF, 23'h0, 4'b0000};
    if (zx || zy) return {s, 31'h0, 4'b0000};
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (1.0 + real'(y[22:0]) / 8388608.0);
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    m   = (m - 1.0) * 8388608.0;
    f   = $rtoi(m);
    rem = m - real'(f);
`ifdef ROUND_NEAREST_EN
    if (rem > 0.5 || (rem == 0.5 && f % 2 == 1)) f++;
`endif
    if (f == 8388608) begin f = 0; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0, 4'b1000};
    if (e <= 0) return {s, 31'h0, 4'b0100};
    return {s, e[7:0], f[22:0], 4'b0000};
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 19);
    r = $urandom;
    if (k == 0) return {r[31], 31'h7F800000};
    if (k == 1) return {r[31], 8'h00, r[22:0]};
    if (k == 2) return {r[31], 8'hFF, r[22:1], 1'b1};
    if (k < 7) return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
    return {r[31], 8'($urandom_range(90, 164)), r[22:0]};
  endfunction

  // Launch one operation once idle; report edges from the accepting edge to done
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int n, output bit got);
    int w;
    w = 0;
    while (busy && w < 200) begin @(posedge clk); #1; w++; end
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mul_start, ovf, unf, inv, tmo} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {busy, done, mul_start, ovf, unf, inv, tmo});
    end
    checks++;
    if ({result, mul_a, mul_b} !== 80'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {result, mul_a, mul_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] da[10], db[10], dr[10];
    logic [3:0]  df[10];
    bit          dsp[10];
    int n, s0;
    bit got;
    da  = '{32'h41880000, 32'h42F80000, 32'h3FC00001, 32'h7F000000, 32'h00800000,
            32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h80000000, 32'h00000001};
    db  = '{32'h430B0000, 32'h44048000, 32'h3FC00001, 32'h7F000000, 32'h00800000,
            32'h3F800000, 32'h7F800000, 32'h40000000, 32'h3F800000, 32'h40000000};
`ifdef ROUND_NEAREST_EN
    dr  = '{32'h4513B000, 32'h47805C00, 32'h40100002, 32'h7F800000, 32'h00000000,
            32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000};
`else
    dr  = '{32'h4513B000, 32'h47805C00, 32'h40100001, 32'h7F800000, 32'h00000000,
            32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000};
`endif
    df  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    dsp = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      lat = 1 + i % 3;
      s0  = starts;
      run_op(da[i], db[i], n, got);
      checks++;
      if (!got) begin errors++; $display("FAIL dir%0d_done no done within bound", i); end
      checks++;
      if (result !== dr[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, result, dr[i]); end
      checks++;
      if ({ovf, unf, inv, tmo} !== df[i]) begin
        errors++; $display("FAIL dir%0d_flags got %b want %b", i, {ovf, unf, inv, tmo}, df[i]);
      end
      checks++;
      if (starts - s0 !== (dsp[i] ? 0 : 1)) begin
        errors++; $display("FAIL dir%0d_mul_start got %0d pulses want %0d", i, starts - s0, dsp[i] ? 0 : 1);
      end
      if (!dsp[i]) begin
        checks++;
        if (n !== 6 + lat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, n, 6 + lat); end
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse done still %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [35:0] exp;
    int n;
    bit got;
    for (int i = 0; i < 60; i++) begin
      x = rand_op(); y = rand_op();
      lat = $urandom_range(1, 6);
      exp = ref_mul(x, y);
      run_op(x, y, n, got);
      checks++;
      if (!got || {result, ovf, unf, inv, tmo} !== exp) begin
        errors++;
        $display("FAIL rand%0d %h*%h got %h/%b want %h/%b", i, x, y, result, {ovf, unf, inv, tmo}, exp[35:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int w;
    logic [35:0] exp;
    exp = ref_mul(32'h40400000, 32'h40A00000);
    lat = 4;
    w = 0;
    while (busy && w < 200) begin @(posedge clk); #1; w++; end
    a = 32'h40400000; b = 32'h40A00000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 32'h7FC00000; b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!done && w < 200) begin @(posedge clk); #1; w++; end
    checks++;
    if ({result, ovf, unf, inv, tmo} !== exp) begin
      errors++; $display("FAIL ignore_start got %h want %h", result, exp[35:4]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle busy %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    hang = 1;
    run_op(32'h3F800000, 32'h40000000, n, got);
    checks++;
    if (!got) begin errors++; $display("FAIL timeout_done no done within bound"); end
    checks++;
    if (result !== 32'h7FC00000 || {ovf, unf, inv, tmo} !== 4'b0001) begin
      errors++; $display("FAIL timeout_result got %h/%b want 7fc00000/0001", result, {ovf, unf, inv, tmo});
    end
    checks++;
    if (n <= TMO || n > TMO + 12) begin errors++; $display("FAIL timeout_latency got %0d want %0d..%0d", n, TMO + 1, TMO + 12); end
    hang = 0;
  endtask

  task automatic test_reset_in_wait();
    int dones;
    int n;
    bit got;
    hang = 1;
    while (busy) begin @(posedge clk); #1; end
    a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, result, tmo} !== 35'h0) begin
      errors++; $display("FAIL rst_wait got busy=%b done=%b result=%h tmo=%b want 0", busy, done, result, tmo);
    end
    dones = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL rst_wait_done got %0d pulses want 0", dones); end
    hang = 0;
    lat = 2;
    run_op(32'h40000000, 32'h40400000, n, got);
    checks++;
    if (!got || result !== 32'h40C00000) begin
      errors++; $display("FAIL rst_recover got %h want 40c00000", result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
